// File: rtl/ppu_fetch_sched_if.sv
// PPU byte-stream bus: tile-memory read port, PPU stb/ack port, host port.
// master = scheduler side, slave = memory/PPU/host side.
interface ppu_fetch_sched_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_req;
    logic [7:0]        mem_rdata;
    logic              mem_ack;
    logic [7:0]        ppu_data;
    logic              ppu_stb;
    logic              ppu_ack;
    logic [7:0]        host_data;
    logic              host_stb;
    logic              host_ack;

    modport master (
        output mem_addr, mem_req, ppu_data, ppu_stb, host_ack,
        input  mem_rdata, mem_ack, ppu_ack, host_data, host_stb
    );

    modport slave (
        input  mem_addr, mem_req, ppu_data, ppu_stb, host_ack,
        output mem_rdata, mem_ack, ppu_ack, host_data, host_stb
    );
endinterface

// File: rtl/ppu_fetch_sched.sv
// Line fetch scheduler: per line sync, reads LINE_BYTES bytes from tile
// memory and pushes them to the PPU. Host port enabled by PPU_SCHED_HOST_EN.
module ppu_fetch_sched #(
    parameter int LINE_BYTES = 32,
    parameter int LINES      = 32,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sync,
    input  logic              vsync,
    input  logic [ADDR_W-1:0] base_addr,
    ppu_fetch_sched_if.master bus,
    output logic              busy,
    output logic              overrun
);
    localparam int BW = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
    localparam int LW = (LINES > 1) ? $clog2(LINES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MREQ = 2'd1,
        PUSH = 2'd2,
        HOST = 2'd3
    } state_t;

    state_t            state;
    logic              sync_q;
    logic              vsync_q;
    logic [ADDR_W-1:0] base_q;
    logic [LW-1:0]     line_idx;
    logic [BW-1:0]     byte_idx;
    logic              restart_q;
    logic              sync_pend;

    logic              sync_rise;
    logic              vsync_rise;
    logic [LW-1:0]     line_cur;
    logic [LW-1:0]     line_inc;
    logic [ADDR_W-1:0] base_cur;
    logic              restart;
    logic              last_byte;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr_nx;

    function automatic logic [ADDR_W-1:0] calc_addr(
        input logic [ADDR_W-1:0] b,
        input logic [LW-1:0]     l,
        input logic [BW-1:0]     i
    );
        return b + ADDR_W'(l) * ADDR_W'(LINE_BYTES) + ADDR_W'(i);
    endfunction

    // Edge detects; vsync zeroes the line index ahead of any same-cycle use
    always_comb begin
        sync_rise  = sync & ~sync_q;
        vsync_rise = vsync & ~vsync_q;
        line_cur   = vsync_rise ? '0 : line_idx;
        line_inc   = (line_cur == LW'(LINES - 1)) ? '0 : line_cur + 1'b1;
        base_cur   = sync_rise ? base_addr : base_q;
        restart    = restart_q | sync_rise;
        last_byte  = (byte_idx == BW'(LINE_BYTES - 1));
        addr0      = calc_addr(base_cur, line_cur, '0);
        addr_nx    = calc_addr(base_cur, line_cur, byte_idx + 1'b1);
    end

    // Fetch/push/host sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            sync_q       <= 1'b0;
            vsync_q      <= 1'b0;
            base_q       <= '0;
            line_idx     <= '0;
            byte_idx     <= '0;
            restart_q    <= 1'b0;
            sync_pend    <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_req  <= 1'b0;
            bus.ppu_data <= '0;
            bus.ppu_stb  <= 1'b0;
            bus.host_ack <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            bus.host_ack <= 1'b0;
            sync_q       <= sync;
            vsync_q      <= vsync;
            if (sync_rise)  base_q   <= base_addr;
            if (vsync_rise) line_idx <= '0;
            unique case (state)
                IDLE: begin
                    if (sync_rise) begin
                        state        <= MREQ;
                        byte_idx     <= '0;
                        bus.mem_req  <= 1'b1;
                        bus.mem_addr <= addr0;
                        busy         <= 1'b1;
                    end
`ifdef PPU_SCHED_HOST_EN
                    else if (bus.host_stb) begin
                        state        <= HOST;
                        bus.ppu_data <= bus.host_data;
                        bus.ppu_stb  <= 1'b1;
                        busy         <= 1'b1;
                    end
`endif
                end
                MREQ: begin
                    if (sync_rise) begin
                        overrun   <= 1'b1;
                        restart_q <= 1'b1;
                    end
                    if (bus.mem_ack) begin
                        if (restart) begin
                            // request already acked; fetched byte is stale
                            restart_q    <= 1'b0;
                            byte_idx     <= '0;
                            bus.mem_addr <= addr0;
                        end else begin
                            state        <= PUSH;
                            bus.mem_req  <= 1'b0;
                            bus.ppu_data <= bus.mem_rdata;
                            bus.ppu_stb  <= 1'b1;
                        end
                    end
                end
                PUSH: begin
                    if (sync_rise) begin
                        overrun   <= 1'b1;
                        restart_q <= 1'b1;
                    end
                    if (bus.ppu_ack) begin
                        bus.ppu_stb <= 1'b0;
                        if (restart) begin
                            state        <= MREQ;
                            restart_q    <= 1'b0;
                            byte_idx     <= '0;
                            bus.mem_req  <= 1'b1;
                            bus.mem_addr <= addr0;
                        end else if (last_byte) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            line_idx <= line_inc;
                        end else begin
                            state        <= MREQ;
                            byte_idx     <= byte_idx + 1'b1;
                            bus.mem_req  <= 1'b1;
                            bus.mem_addr <= addr_nx;
                        end
                    end
                end
                HOST: begin
                    if (sync_rise) sync_pend <= 1'b1;
                    if (bus.ppu_ack) begin
                        bus.ppu_stb  <= 1'b0;
                        bus.host_ack <= 1'b1;
                        if (sync_pend | sync_rise) begin
                            state        <= MREQ;
                            sync_pend    <= 1'b0;
                            byte_idx     <= '0;
                            bus.mem_req  <= 1'b1;
                            bus.mem_addr <= addr0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ppu_fetch_sched.sv
// Directed bench for ppu_fetch_sched: memory and PPU responders ack one
// cycle after request; handshakes are logged and checked against constants.
module tb_ppu_fetch_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sync = 1'b0;
    logic        vsync = 1'b0;
    logic [15:0] base_addr = 16'h1000;
    logic        busy;
    logic        overrun;

    ppu_fetch_sched_if #(.ADDR_W(16)) bus ();

    ppu_fetch_sched #(
        .LINE_BYTES(32),
        .LINES(32),
        .ADDR_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sync(sync),
        .vsync(vsync),
        .base_addr(base_addr),
        .bus(bus),
        .busy(busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] addr_q[$];
    logic [7:0]  data_q[$];
    int          drop_cnt = 0;
    int          hack_cnt = 0;
    int          hack_at = 0;
    logic        stb_prev = 1'b0;
    logic        req_prev = 1'b0;
    localparam logic [15:0] BASE = 16'h1000;

    function automatic logic [7:0] mem_fn(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h00;
        bus.ppu_ack   = 1'b0;
        bus.host_data = 8'h00;
        bus.host_stb  = 1'b0;
    end

    // Memory/PPU/host responders and handshake logger
    always @(negedge clk) begin
        if (rst) begin
            bus.mem_ack = 1'b0;
            bus.ppu_ack = 1'b0;
            stb_prev = 1'b0;
            req_prev = 1'b0;
        end else begin
            if (stb_prev && !bus.ppu_stb && !bus.ppu_ack) drop_cnt++;
            if (req_prev && !bus.mem_req && !bus.mem_ack) drop_cnt++;
            stb_prev = bus.ppu_stb;
            req_prev = bus.mem_req;
            if (bus.mem_req && !bus.mem_ack) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mem_fn(bus.mem_addr);
                addr_q.push_back(bus.mem_addr);
            end else begin
                bus.mem_ack = 1'b0;
            end
            if (bus.ppu_stb && !bus.ppu_ack) begin
                bus.ppu_ack = 1'b1;
                data_q.push_back(bus.ppu_data);
            end else begin
                bus.ppu_ack = 1'b0;
            end
            if (bus.host_ack) begin
                hack_cnt++;
                hack_at = data_q.size();
                bus.host_stb = 1'b0;
            end
        end
    end

    task automatic pulse_sync();
        @(negedge clk); #1;
        sync = 1'b1;
        @(negedge clk); #1;
        sync = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 400) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic run_line();
        addr_q.delete();
        data_q.delete();
        pulse_sync();
        wait_idle();
    endtask

    initial begin
        int n;
        int stb_hi;
        int ack_hi;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_ppu_data", 32'(bus.ppu_data), 32'd0);
        chk("rst_ppu_stb", 32'(bus.ppu_stb), 32'd0);
        chk("rst_host_ack", 32'(bus.host_ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;

        run_line();
        chk("l0_count", 32'(data_q.size()), 32'd32);
        for (int i = 0; i < 32; i++) begin
            if (i < addr_q.size())
                chk("l0_addr", 32'(addr_q[i]), 32'(BASE + 16'(i)));
            if (i < data_q.size())
                chk("l0_data", 32'(data_q[i]), 32'(mem_fn(BASE + 16'(i))));
        end
        chk("l0_busy", 32'(busy), 32'd0);
        chk("l0_drops", 32'(drop_cnt), 32'd0);

        run_line();
        chk("l1_first", 32'(addr_q[0]), 32'h1020);

        for (int l = 2; l < 32; l++) begin
            run_line();
            chk("line_count", 32'(data_q.size()), 32'd32);
        end
        chk("l31_first", 32'(addr_q[0]), 32'(BASE + 16'd992));
        chk("l31_last", 32'(addr_q[31]), 32'(BASE + 16'd1023));

        run_line();
        chk("wrap_first", 32'(addr_q[0]), 32'(BASE));
        run_line();
        chk("l1b_first", 32'(addr_q[0]), 32'h1020);

        @(negedge clk); #1;
        vsync = 1'b1;
        @(negedge clk); #1;
        vsync = 1'b0;
        run_line();
        chk("vsync_first", 32'(addr_q[0]), 32'(BASE));
        chk("pre_ovr", 32'(overrun), 32'd0);

        addr_q.delete();
        data_q.delete();
        pulse_sync();
        n = 0;
        while (data_q.size() < 10 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        chk("ovr_wait", 32'(data_q.size()), 32'd10);
        sync = 1'b1;
        @(negedge clk); #1;
        sync = 1'b0;
        wait_idle();
        chk("ovr_flag", 32'(overrun), 32'd1);
        chk("ovr_restart", 32'(addr_q[10]), 32'h1020);
        chk("ovr_count", 32'(data_q.size()), 32'd42);
        chk("ovr_drops", 32'(drop_cnt), 32'd0);
        if (data_q.size() == 42)
            chk("ovr_last", 32'(data_q[41]), 32'(mem_fn(16'h103F)));

        run_line();
        chk("post_ovr", 32'(addr_q[0]), 32'h1040);
        chk("ovr_sticky", 32'(overrun), 32'd1);

`ifdef PPU_SCHED_HOST_EN
        addr_q.delete();
        data_q.delete();
        hack_cnt = 0;
        pulse_sync();
        repeat (6) @(negedge clk);
        #1;
        bus.host_data = 8'hA5;
        bus.host_stb = 1'b1;
        n = 0;
        while (hack_cnt == 0 && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        chk("host_ack_cnt", 32'(hack_cnt), 32'd1);
        chk("host_ack_at", 32'(hack_at), 32'd33);
        chk("host_total", 32'(data_q.size()), 32'd33);
        if (data_q.size() == 33)
            chk("host_byte", 32'(data_q[32]), 32'hA5);
`else
        stb_hi = 0;
        ack_hi = 0;
        bus.host_data = 8'hA5;
        bus.host_stb = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (bus.ppu_stb) stb_hi++;
            if (bus.host_ack) ack_hi++;
        end
        bus.host_stb = 1'b0;
        chk("nohost_stb", 32'(stb_hi), 32'd0);
        chk("nohost_ack", 32'(ack_hi), 32'd0);
        chk("nohost_busy", 32'(busy), 32'd0);
`endif

        pulse_sync();
        repeat (5) @(negedge clk);
        #1;
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("mid_rst_req", 32'(bus.mem_req), 32'd0);
        chk("mid_rst_stb", 32'(bus.ppu_stb), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ovr", 32'(overrun), 32'd0);
        chk("mid_rst_addr", 32'(bus.mem_addr), 32'd0);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
